// File: rtl/eight_bit_deserializer_if.sv
// ============================================================================
// Module   : eight_bit_deserializer_if
// Brief    : Serial-in / word-out bundle for the 8:1 link receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface eight_bit_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             din;
  logic             din_valid;
  logic             frame_start;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             overflow;

  // Master drives the serial stream and consumes words.
  modport master (
    output din, din_valid, frame_start, q_ready,
    input  bit_idx, q, q_valid, overflow
  );

  // Slave is the deserializer itself.
  modport slave (
    input  din, din_valid, frame_start, q_ready,
    output bit_idx, q, q_valid, overflow
  );
endinterface

`default_nettype wire

// File: rtl/eight_bit_deserializer.sv
// ============================================================================
// Module   : eight_bit_deserializer
// Brief    : Rebuilds WIDTH-bit words from the 8:1 mux serial stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eight_bit_deserializer #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  eight_bit_deserializer_if.slave  bus
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  // Only the first WIDTH-1 bits need storage; the last bit goes straight to q.
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-2:0] w_shift_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_q_valid;
  logic             w_q_valid_nxt;
  logic             r_overflow;
  logic             w_overflow_nxt;
  logic             w_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_idx      <= '0;
      r_shift    <= '0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_q        <= w_q_nxt;
      r_q_valid  <= w_q_valid_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_q_nxt        = r_q;
    w_q_valid_nxt  = r_q_valid;
    w_overflow_nxt = r_overflow;
    w_complete     = 1'b0;

    case (r_state)
      ST_HUNT: begin
        if (bus.frame_start) begin
          w_state_nxt = ST_RECV;
          if (bus.din_valid) begin
            w_shift_nxt[0] = bus.din;
            w_idx_nxt      = C_IDX_ONE;
          end else begin
            w_idx_nxt      = '0;
          end
        end
      end

      ST_RECV: begin
        // A frame marker always wins: the current bit becomes bit 0.
        if (bus.frame_start) begin
          if (bus.din_valid) begin
            w_shift_nxt[0] = bus.din;
            w_idx_nxt      = C_IDX_ONE;
          end else begin
            w_idx_nxt      = '0;
          end
        end else if (bus.din_valid) begin
          if (r_idx == C_LAST_IDX) begin
            w_complete = 1'b1;
            w_idx_nxt  = '0;
          end else begin
            w_shift_nxt[r_idx] = bus.din;
            w_idx_nxt          = r_idx + C_IDX_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_HUNT;
        w_idx_nxt   = '0;
      end
    endcase

    // Output slot: a finished word loads only if the slot is free or draining now.
    if (w_complete) begin
      if (!r_q_valid || bus.q_ready) begin
        w_q_nxt       = {bus.din, r_shift};
        w_q_valid_nxt = 1'b1;
      end else begin
        w_overflow_nxt = 1'b1;
      end
    end else if (r_q_valid && bus.q_ready) begin
      w_q_valid_nxt = 1'b0;
    end
  end

  assign bus.bit_idx  = r_idx;
  assign bus.q        = r_q;
  assign bus.q_valid  = r_q_valid;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_eight_bit_deserializer.sv
// ============================================================================
// Module   : tb_eight_bit_deserializer
// Brief    : Directed and random checks of the serial word receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eight_bit_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eight_bit_deserializer_if #(.WIDTH(8), .IDX_W(3)) bus ();

  eight_bit_deserializer #(.WIDTH(8), .IDX_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a list of collected bits plus a single output slot.
  bit         m_hunt = 1'b1;
  int         m_cnt  = 0;
  logic [7:0] m_word = '0;
  logic [7:0] m_q    = '0;
  bit         m_qv   = 1'b0;
  bit         m_ovf  = 1'b0;

  function automatic void model_update(input logic d, input logic dv,
                                       input logic fs, input logic rdy);
    bit         done;
    logic [7:0] fresh;
    done  = 1'b0;
    fresh = '0;
    if (rst) begin
      m_hunt = 1'b1; m_cnt = 0; m_word = '0; m_q = '0; m_qv = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (fs) begin
      if (m_hunt || 1'b1) m_hunt = 1'b0;
      if (dv) begin m_word[0] = d; m_cnt = 1; end
      else m_cnt = 0;
    end else if (!m_hunt && dv) begin
      m_word[m_cnt] = d;
      m_cnt = m_cnt + 1;
      if (m_cnt == 8) begin
        done  = 1'b1;
        fresh = m_word;
        m_cnt = 0;
      end
    end
    if (done) begin
      if (!m_qv || rdy) begin m_q = fresh; m_qv = 1'b1; end
      else m_ovf = 1'b1;
    end else if (m_qv && rdy) begin
      m_qv = 1'b0;
    end
  endfunction

  task automatic tick(input logic d, input logic dv, input logic fs, input logic rdy);
    bus.din = d; bus.din_valid = dv; bus.frame_start = fs; bus.q_ready = rdy;
    @(posedge clk);
    model_update(d, dv, fs, rdy);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit framed, input logic rdy);
    for (int i = 0; i < 8; i++) tick(w[i], 1'b1, framed && (i == 0), rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q actual=%h expected=00", bus.q); end
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL reset_qv actual=%b expected=0", bus.q_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b expected=0", bus.overflow); end
    checks++; if (bus.bit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx actual=%0d expected=0", bus.bit_idx); end
  endtask

  task automatic test_basic_word();
    logic [7:0] w;
    w = 8'h86;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(w[i], 1'b1, i == 0, 1'b1);
      if (i < 7) begin
        checks++; if (bus.bit_idx !== 3'(i + 1)) begin errors++; $display("FAIL basic_idx actual=%0d expected=%0d", bus.bit_idx, i + 1); end
        checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL basic_early_qv actual=%b expected=0", bus.q_valid); end
      end
    end
    checks++; if (bus.q !== 8'h86) begin errors++; $display("FAIL basic_q actual=%h expected=86", bus.q); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL basic_qv actual=%b expected=1", bus.q_valid); end
    checks++; if (bus.bit_idx !== 3'd0) begin errors++; $display("FAIL basic_idx_wrap actual=%0d expected=0", bus.bit_idx); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL basic_qv_drop actual=%b expected=0", bus.q_valid); end
    checks++; if (bus.q !== 8'h86) begin errors++; $display("FAIL basic_q_hold actual=%h expected=86", bus.q); end
  endtask

  task automatic test_hunt();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'($urandom), 1'b1, 1'b0, 1'b1);
      checks++; if (bus.bit_idx !== 3'd0) begin errors++; $display("FAIL hunt_idx actual=%0d expected=0", bus.bit_idx); end
      checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL hunt_qv actual=%b expected=0", bus.q_valid); end
    end
    send_word(8'hA5, 1'b1, 1'b1);
    checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL hunt_q actual=%h expected=a5", bus.q); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL hunt_qv_after actual=%b expected=1", bus.q_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(8'h3C, 1'b1, 1'b0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early actual=%b expected=0", bus.overflow); end
    send_word(8'hFF, 1'b0, 1'b0);
    checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL ovf_q actual=%h expected=3c", bus.q); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL ovf_qv actual=%b expected=1", bus.q_valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag actual=%b expected=1", bus.overflow); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_qv actual=%b expected=0", bus.q_valid); end
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%b expected=1", bus.overflow); end
    do_reset();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear actual=%b expected=0", bus.overflow); end
  endtask

  task automatic test_realign();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'($urandom), 1'b1, i == 0, 1'b1);
    checks++; if (bus.bit_idx !== 3'd4) begin errors++; $display("FAIL realign_partial_idx actual=%0d expected=4", bus.bit_idx); end
    for (int i = 0; i < 8; i++) begin
      tick(i == 3 || i == 4 || i == 6 || i == 1, 1'b1, i == 0, 1'b1);
      if (i < 7) begin
        checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL realign_partial_qv actual=%b expected=0", bus.q_valid); end
      end
    end
    checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL realign_q actual=%h expected=5a", bus.q); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL realign_ovf actual=%b expected=0", bus.overflow); end
    // frame_start alone in RECV drops the partial word.
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.bit_idx !== 3'd0) begin errors++; $display("FAIL realign_fs_alone actual=%0d expected=0", bus.bit_idx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h34;
    do_reset();
    send_word(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick(w[i], 1'b1, 1'b0, 1'b0);
    checks++; if (bus.q !== 8'h12) begin errors++; $display("FAIL b2b_first_q actual=%h expected=12", bus.q); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_qv actual=%b expected=1", bus.q_valid); end
    tick(w[7], 1'b1, 1'b0, 1'b1);
    checks++; if (bus.q !== 8'h34) begin errors++; $display("FAIL b2b_second_q actual=%h expected=34", bus.q); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_qv actual=%b expected=1", bus.q_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf actual=%b expected=0", bus.overflow); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'hC3;
    do_reset();
    send_word(8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'($urandom), 1'b1, i == 0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL mid_rst_q actual=%h expected=00", bus.q); end
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_qv actual=%b expected=0", bus.q_valid); end
    checks++; if (bus.bit_idx !== 3'd0) begin errors++; $display("FAIL mid_rst_idx actual=%0d expected=0", bus.bit_idx); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf actual=%b expected=0", bus.overflow); end
    for (int i = 0; i < 8; i++) tick(w[i], 1'b1, i == 0, 1'b1);
    checks++; if (bus.q !== 8'hC3) begin errors++; $display("FAIL mid_rst_next_q actual=%h expected=c3", bus.q); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      tick(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 6);
      rst = 1'b0;
      checks++;
      if (bus.q !== m_q || bus.q_valid !== m_qv || bus.overflow !== m_ovf ||
          bus.bit_idx !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL rand_cycle%0d actual q=%h v=%b ovf=%b idx=%0d expected q=%h v=%b ovf=%b idx=%0d",
                 n, bus.q, bus.q_valid, bus.overflow, bus.bit_idx, m_q, m_qv, m_ovf, m_cnt);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.frame_start = 1'b0; bus.q_ready = 1'b0;
    test_reset();
    test_basic_word();
    test_hunt();
    test_overflow();
    test_realign();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
